seg7_scan_ctrl: RTL
===================

// Module: seg7_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
//  Shares one BCD-to-7-segment decoder between DIGITS digit positions: presents one
//  BCD nibble at a time on bcd_out and enables the matching active-low anode.
//  Double-buffers the displayed value and commits new values only at frame boundaries,
//  so the display never tears mid-frame. Inserts a blanking gap between digits to stop ghosting.
// PARAMETERS
//  DIGITS     4     number of digit positions scanned (>=2)
//  SHOW_CYC   1000  clocks per digit with its anode enabled (>=1)
//  BLANK_CYC  8     clocks with all anodes off before each digit (>=1)
// PORTS
//  clk        in   1         single system clock, rising edge
//  rst_n      in   1         asynchronous active-low reset
//  en         in   1         scan enable; 0 = display dark
//  load       in   1         1-cycle strobe: capture digits_in into the staging register
//  digits_in  in   4*DIGITS  BCD digits, [3:0] = digit 0 (rightmost, least significant)
//  bcd_out    out  4         BCD nibble to the shared decoder (A=bit3 ... D=bit0)
//  an_n       out  DIGITS    anode enables, active-low, at most one bit low at any time
//  frame_done out  1         1-cycle pulse at each frame boundary
// BEHAVIOUR
//  - Reset: an_n all 1s, bcd_out=0, frame_done=0. Staging and shadow registers clear to 0.
//    pending=0, state=BLANK, idx=0, cnt=0. All outputs are registered.
//  - States BLANK and SHOW. cnt counts from 0 within each state.
//    Counter width is $clog2(max(SHOW_CYC,BLANK_CYC)).
//  - BLANK: an_n all 1s; bcd_out = shadow[idx]. After BLANK_CYC cycles -> SHOW.
//  - SHOW: an_n[idx]=0, all other bits 1; bcd_out is held.
//    After SHOW_CYC cycles -> BLANK, and idx advances by 1 (DIGITS-1 wraps to 0).
//  - bcd_out changes only on entry to BLANK, so the decoder settles while the anodes are dark.
//  - Frame period = DIGITS*(SHOW_CYC+BLANK_CYC) clocks.
//  - Frame boundary is the SHOW(idx=DIGITS-1) -> BLANK(idx=0) transition. On the first
//    BLANK cycle of the new frame: frame_done=1 for one cycle.
//    If pending=1 at the boundary: shadow<=staging and pending<=0.
//  - load=1 on any cycle: staging<=digits_in, pending<=1. A later load before the
//    boundary overwrites the earlier one (last write wins).
//  - load coinciding with the boundary cycle: digits_in is written directly into the
//    shadow used by the new frame, and pending ends at 0.
//  - Nibbles > 9 pass through unchanged; decoding them is the decoder's concern.
//  - en=0: on the next cycle state=BLANK, cnt=0, an_n all 1s.
//    idx holds, frame_done stays 0, and load still stages the value.
//  - en rising: scanning resumes with a full BLANK of the held idx.
//  - rst_n asserted mid-frame: immediate return to reset values; staged data is lost.
// CONFIGURATION
//  SEG7_LZ_SUPPRESS_EN defined: leading-zero suppression.
//    During SHOW of idx, an_n stays all 1s when idx > the index of the highest nonzero
//    shadow digit. Digit 0 is always shown, so an all-zero value displays a single "0".
//    Slot timing and frame_done are unchanged.
//  SEG7_LZ_SUPPRESS_EN undefined: every digit position is lit in its slot, zeros included.
// TESTING  (DIGITS=4, SHOW_CYC=4, BLANK_CYC=2 unless noted)
//  1. Release reset, en=1, no load -> an_n=1111 for 2 clk, then 1110 for 4 clk,
//     1111 for 2 clk, then 1101; bcd_out=0; frame_done every 24 clk.
//  2. load digits_in=16'h1234 mid-frame -> display is unchanged until frame_done.
//     Next frame: bcd_out=4,3,2,1 while an_n=1110,1101,1011,0111.
//  3. load 16'h5678 then 16'h9012 in the same frame -> next frame shows 9012 only.
//     load on the boundary cycle -> that same frame shows the new value.
//  4. en=0 mid-SHOW of digit 2 -> next cycle an_n=1111 and stays; en=1 ->
//     2 clk BLANK, then an_n=1011.
//  5. SEG7_LZ_SUPPRESS_EN, shadow=16'h0042 -> digits 3 and 2 dark in their slots,
//     1/0 lit with bcd_out 4/2. shadow=0 -> only digit 0 lit, bcd_out 0.
//  6. Assert rst_n low mid-SHOW with pending=1 -> an_n=1111, bcd_out=0 asynchronously.
//     After release, shadow and pending are 0.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment scanner with frame-synchronous double buffering.
// Define SEG7_LZ_SUPPRESS_EN to blank leading-zero digit positions.
module seg7_scan_ctrl #(
    parameter int DIGITS    = 4,
    parameter int SHOW_CYC  = 1000,
    parameter int BLANK_CYC = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                load,
    input  logic [4*DIGITS-1:0] digits_in,
    output logic [3:0]          bcd_out,
    output logic [DIGITS-1:0]   an_n,
    output logic                frame_done
);
    localparam int MAXC = SHOW_CYC > BLANK_CYC ? SHOW_CYC : BLANK_CYC;
    localparam int CW   = MAXC > 1 ? $clog2(MAXC) : 1;
    localparam int IW   = $clog2(DIGITS);
    localparam logic [0:0] BLANK = 1'b0;
    localparam logic [0:0] SHOW  = 1'b1;

    logic [0:0]          state, state_n;
    logic [IW-1:0]       idx, idx_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [4*DIGITS-1:0] staging, shadow, shadow_n;
    logic                pending, pending_n, boundary, lit;

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        cnt_n    = cnt + CW'(1);
        boundary = 1'b0;
        if (!en) begin
            state_n = BLANK;
            cnt_n   = '0;
        end else if (state == BLANK && cnt == CW'(BLANK_CYC - 1)) begin
            state_n = SHOW;
            cnt_n   = '0;
        end else if (state == SHOW && cnt == CW'(SHOW_CYC - 1)) begin
            state_n  = BLANK;
            cnt_n    = '0;
            boundary = idx == IW'(DIGITS - 1);
            idx_n    = boundary ? '0 : idx + IW'(1);
        end
        // A load landing on the boundary goes straight into the new frame's shadow.
        shadow_n  = boundary ? (load ? digits_in : (pending ? staging : shadow)) : shadow;
        pending_n = load ? !boundary : (boundary ? 1'b0 : pending);
    end

`ifdef SEG7_LZ_SUPPRESS_EN
    logic [IW-1:0] hi;

    always_comb begin
        hi = '0;
        for (int i = 1; i < DIGITS; i++)
            if (shadow[4*i +: 4] != 4'd0) hi = IW'(i);
        lit = idx_n <= hi;
    end
`else
    assign lit = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BLANK;
            idx        <= '0;
            cnt        <= '0;
            staging    <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            an_n       <= '1;
            bcd_out    <= 4'd0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            staging    <= load ? digits_in : staging;
            shadow     <= shadow_n;
            pending    <= pending_n;
            an_n       <= (state_n == SHOW && lit) ? ~(DIGITS'(1) << idx_n) : '1;
            bcd_out    <= state_n == BLANK ? shadow_n[4*int'(idx_n) +: 4] : bcd_out;
            frame_done <= boundary;
        end
    end
endmodule
